// File: rtl/regfile_reader.sv
// regfile_reader
// Sequential read-out engine for the register file. A start command latches
// an address range; the engine then walks it through one combinational read
// port and presents each (address, data) pair on a valid/ready stream.
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high. Once out_valid is raised, out_addr/out_data are held until
// that transfer (or an abort/reset withdraws the word).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a walk (sampled only when idle)
//   first_addr          first register of the range (sampled with start)
//   last_addr           last register of the range (sampled with start)
//   abort               end an active walk early
//   rd_address          register file read address (valid while reading)
//   rd_data             register file read data for rd_address
//   out_valid/out_ready stream handshake
//   out_addr/out_data   register index and contents of the current word
//   busy                high whenever a walk or its completion is in flight
//   done                one-cycle pulse when a walk completes or is aborted
//   state_dbg           current FSM state, for observation only
module regfile_reader #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter bit SKIP_ZERO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic              abort,
   output logic [ADDR_W-1:0] rd_address,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        state_dbg
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

   logic [1:0]        state;
   logic [ADDR_W-1:0] cur;
   logic [ADDR_W-1:0] end_addr;
   logic [ADDR_W-1:0] next_cur;
   logic              last_word;

   // Address following cur, stepping over x0 when it is never emitted.
   always_comb begin
      next_cur = cur + ADDR_ONE;
      if (SKIP_ZERO && (next_cur == ADDR_ZERO)) begin
         next_cur = ADDR_ONE;
      end
   end

   // With x0 skipped, a range ending at 0 really ends at the top address,
   // otherwise the walk would step past its end and never terminate.
   always_comb begin
      last_word = (cur == end_addr);
      if (SKIP_ZERO && (end_addr == ADDR_ZERO) && (cur == ADDR_MAX)) begin
         last_word = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cur       <= '0;
         end_addr  <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  end_addr <= last_addr;
                  if (SKIP_ZERO && (first_addr == ADDR_ZERO)) begin
                     cur <= ADDR_ONE;
                     // Range consisting of x0 alone: nothing to emit.
                     state <= (last_addr == ADDR_ZERO) ? S_FIN : S_READ;
                  end else begin
                     cur   <= first_addr;
                     state <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (abort) begin
                  state <= S_FIN;
               end else begin
                  out_addr  <= cur;
                  out_data  <= rd_data;
                  out_valid <= 1'b1;
                  state     <= S_SEND;
               end
            end
            S_SEND: begin
               // A word accepted together with abort has still transferred.
               if (abort) begin
                  out_valid <= 1'b0;
                  state     <= S_FIN;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  if (last_word) begin
                     state <= S_FIN;
                  end else begin
                     cur   <= next_cur;
                     state <= S_READ;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_address = cur;
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_FIN);
   assign state_dbg  = state;

endmodule
